// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to Unicode scalar decoder with WHATWG-style error recovery and an output FIFO.
// Define UTF8_STREAM_DECODER_ERROR_COUNT_EN to add the saturating err_count output.
module utf8_stream_decoder #(
    parameter int FIFO_DEPTH       = 4,
    parameter int REPLACE_ON_ERROR = 1,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [20:0]            out_codepoint,
    output logic                   out_error,
    output logic                   out_last
`ifdef UTF8_STREAM_DECODER_ERROR_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] err_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [20:0] ERR_CP = (REPLACE_ON_ERROR != 0) ? 21'h00FFFD : 21'h0;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state, state_n;
    logic [1:0]  bytes_needed, bytes_needed_n;
    logic [1:0]  bytes_seen, bytes_seen_n;
    logic [7:0]  lower, lower_n, upper, upper_n;
    logic [20:0] acc, acc_n, new_acc;
    logic        pending_valid, pending_valid_n;
    logic [7:0]  pending_data, pending_data_n;
    logic        pending_last, pending_last_n;

    logic [22:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, pop;

    logic        proc_valid, proc_last;
    logic [7:0]  proc_byte;
    logic        push, push_err, push_last;
    logic [20:0] push_cp;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign in_ready  = reset && !fifo_full && !pending_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign out_codepoint = out_valid ? mem[rd_ptr][22:2] : 21'h0;
    assign out_error     = out_valid ? mem[rd_ptr][1]    : 1'b0;
    assign out_last      = out_valid ? mem[rd_ptr][0]    : 1'b0;

    // A pending byte takes priority over the input port and only waits for FIFO space.
    assign proc_valid = pending_valid ? !fifo_full : (in_valid && in_ready);
    assign proc_byte  = pending_valid ? pending_data : in_data;
    assign proc_last  = pending_valid ? pending_last : in_last;

    always_comb begin
        state_n         = state;
        bytes_needed_n  = bytes_needed;
        bytes_seen_n    = bytes_seen;
        lower_n         = lower;
        upper_n         = upper;
        acc_n           = acc;
        pending_valid_n = pending_valid;
        pending_data_n  = pending_data;
        pending_last_n  = pending_last;
        push            = 1'b0;
        push_cp         = 21'h0;
        push_err        = 1'b0;
        push_last       = 1'b0;
        new_acc         = {acc[14:0], proc_byte[5:0]};

        if (proc_valid) begin
            if (pending_valid)
                pending_valid_n = 1'b0;
            if (state == IDLE) begin
                lower_n      = 8'h80;
                upper_n      = 8'hBF;
                bytes_seen_n = 2'd0;
                if (proc_byte <= 8'h7F) begin
                    push      = 1'b1;
                    push_cp   = {13'h0, proc_byte};
                    push_last = proc_last;
                end else if (proc_byte >= 8'hC2 && proc_byte <= 8'hF4) begin
                    state_n = COLLECT;
                    if (proc_byte <= 8'hDF) begin
                        bytes_needed_n = 2'd1;
                        acc_n          = {16'h0, proc_byte[4:0]};
                    end else if (proc_byte <= 8'hEF) begin
                        bytes_needed_n = 2'd2;
                        acc_n          = {17'h0, proc_byte[3:0]};
                        if (proc_byte == 8'hE0) lower_n = 8'hA0;
                        if (proc_byte == 8'hED) upper_n = 8'h9F;
                    end else begin
                        bytes_needed_n = 2'd3;
                        acc_n          = {18'h0, proc_byte[2:0]};
                        if (proc_byte == 8'hF0) lower_n = 8'h90;
                        if (proc_byte == 8'hF4) upper_n = 8'h8F;
                    end
                    // A multi-byte lead that ends the stream is a truncated sequence.
                    if (proc_last) begin
                        state_n        = IDLE;
                        bytes_needed_n = 2'd0;
                        acc_n          = 21'h0;
                        lower_n        = 8'h80;
                        upper_n        = 8'hBF;
                        push           = 1'b1;
                        push_cp        = ERR_CP;
                        push_err       = 1'b1;
                        push_last      = 1'b1;
                    end
                end else begin
                    push      = 1'b1;
                    push_cp   = ERR_CP;
                    push_err  = 1'b1;
                    push_last = proc_last;
                end
            end else if (proc_byte >= lower && proc_byte <= upper) begin
                lower_n = 8'h80;
                upper_n = 8'hBF;
                if (bytes_seen + 2'd1 == bytes_needed) begin
                    push           = 1'b1;
                    push_cp        = new_acc;
                    push_last      = proc_last;
                    state_n        = IDLE;
                    bytes_needed_n = 2'd0;
                    bytes_seen_n   = 2'd0;
                    acc_n          = 21'h0;
                end else if (proc_last) begin
                    push           = 1'b1;
                    push_cp        = ERR_CP;
                    push_err       = 1'b1;
                    push_last      = 1'b1;
                    state_n        = IDLE;
                    bytes_needed_n = 2'd0;
                    bytes_seen_n   = 2'd0;
                    acc_n          = 21'h0;
                end else begin
                    bytes_seen_n = bytes_seen + 2'd1;
                    acc_n        = new_acc;
                end
            end else begin
                // The rejected byte is kept and replayed as a lead byte next cycle.
                push            = 1'b1;
                push_cp         = ERR_CP;
                push_err        = 1'b1;
                state_n         = IDLE;
                bytes_needed_n  = 2'd0;
                bytes_seen_n    = 2'd0;
                acc_n           = 21'h0;
                lower_n         = 8'h80;
                upper_n         = 8'hBF;
                pending_valid_n = 1'b1;
                pending_data_n  = proc_byte;
                pending_last_n  = proc_last;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            bytes_needed  <= 2'd0;
            bytes_seen    <= 2'd0;
            lower         <= 8'h80;
            upper         <= 8'hBF;
            acc           <= 21'h0;
            pending_valid <= 1'b0;
            pending_data  <= 8'h0;
            pending_last  <= 1'b0;
        end else begin
            state         <= state_n;
            bytes_needed  <= bytes_needed_n;
            bytes_seen    <= bytes_seen_n;
            lower         <= lower_n;
            upper         <= upper_n;
            acc           <= acc_n;
            pending_valid <= pending_valid_n;
            pending_data  <= pending_data_n;
            pending_last  <= pending_last_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {push_cp, push_err, push_last};
    end

`ifdef UTF8_STREAM_DECODER_ERROR_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset)
            err_count <= '0;
        else if (push && push_err && err_count != '1)
            err_count <= err_count + COUNT_WIDTH'(1);
    end
`endif

endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
- Streaming UTF-8 to Unicode scalar decoder with valid/ready handshakes on both sides.
- Input: one byte per transfer. Output: a FIFO of decoded items.
- Generalises the single-byte status-style decoder with:
  - parametrised output buffering,
  - WHATWG-style error recovery: the offending byte is reprocessed, and U+FFFD replacement is optional,
  - end-of-stream handling.
- Sits between a byte-oriented transport and text-processing consumers.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- REPLACE_ON_ERROR, 1, 1: error items carry codepoint 21'hFFFD; 0: error items carry 21'h0.
- COUNT_WIDTH, 16, width of error counter (used only with the optional feature).

Ports:
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- in_valid  input  1  byte available.
- in_ready  output  1  decoder accepts byte this cycle.
- in_data  input  8  input octet.
- in_last  input  1  byte is final of stream.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head.
- out_codepoint  output  21  decoded scalar, or replacement value.
- out_error  output  1  item is an error item.
- out_last  output  1  item is final of stream.

Behaviour:
- Reset state:
  - FIFO empty; out_valid=0; out_codepoint=0; out_error=0; out_last=0.
  - in_ready=0 while reset is asserted.
  - Decoder state IDLE; bytes_needed=0; bytes_seen=0; lower=8'h80; upper=8'hBF.
  - Pending register cleared.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output pop when out_valid && out_ready.
- in_ready = !fifo_full && !pending_valid. It is registered-state only and never depends on in_data.
- FIFO:
  - Pop and push in the same cycle are legal when full; in_ready still reflects pre-pop fullness.
  - Ordering is strict.
- Latency: an item produced by a byte accepted at cycle N is visible on out_valid at N+1 when the FIFO is empty.
- Lead-byte classification in IDLE:
  - 00-7F: push the codepoint.
  - C2-DF: need 1; acc = b&1F.
  - E0-EF: need 2; acc = b&0F. E0 sets lower=A0; ED sets upper=9F.
  - F0-F4: need 3; acc = b&07. F0 sets lower=90; F4 sets upper=8F.
  - Anything else: push an error item; the byte is consumed.
- COLLECT state:
  - A byte in [lower, upper]:
    - acc = (acc<<6) | (b&3F); bounds revert to 80/BF.
    - If bytes_seen+1 == bytes_needed: push acc and return to IDLE.
    - Otherwise bytes_seen++.
  - A byte out of range:
    - Push an error item, clear acc and counters, reset bounds, return to IDLE.
    - Store the byte and its in_last flag in the pending register.
- Pending reprocess:
  - The next cycle, the pending byte is processed as a lead byte in IDLE, with in_ready=0.
  - It stalls while the FIFO is full; pending clears once processed.
- End of stream:
  - An accepted byte with in_last=1 that completes a scalar, or is an error lead, produces an item with out_last=1.
  - If in_last=1 arrives on a lead byte or a valid non-final continuation (sequence truncated), push one error item with out_last=1 and return to IDLE.
  - For an out-of-range continuation with in_last=1: the first error item has out_last=0, and the reprocessed byte's item carries out_last=1.
- Surrogates (D800-DFFF) and values above 10FFFF are unreachable by the bound rules; no extra check is needed.
- When fifo_full, no byte is consumed and decoder state holds.
- Reset mid-sequence discards the partial scalar, pending byte and FIFO contents.

Optional Feature:
- Macro: UTF8_STREAM_DECODER_ERROR_COUNT_EN.
- Defined:
  - Adds output port err_count[COUNT_WIDTH-1:0]: a saturating count of error items pushed.
  - Cleared by reset; increments on the push cycle and holds at all-ones.
- Undefined: the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Bytes 41, E2, 82, AC, out_ready=1 -> items 0x41 (error=0), then 0x20AC; the first item is visible one cycle after acceptance.
- E0, 80 -> error item FFFD; 80 is reprocessed as a lead -> a second error item. Total 2 errors, in_ready=0 in the reprocess cycle.
- ED, A0, 80 -> three error items (A0 rejected by upper=9F, then A0 and 80 each invalid as leads). err_count=3 when the macro is defined.
- F0, 9F, 98, 80 repeated 6 times with out_ready=0 and FIFO_DEPTH=4:
  - in_ready drops after 4 items are buffered.
  - Releasing out_ready yields 0x1F600 six times, in order, with no loss.
- C3 with in_last=1 -> a single error item with out_last=1; a subsequent 41 decodes normally to 0x41.
- Reset asserted (reset=0) after E2, 82 -> outputs cleared; following 41 -> 0x41 with no stale error.
- REPLACE_ON_ERROR=0, byte FF -> error item with codepoint 0.
